// File: rtl/mesif_pkg.sv
// rtl/mesif_pkg.sv - shared opcodes, MESIF encodings and address geometry
package mesif_pkg;

  localparam int TAG_W    = 12;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 6;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
  localparam int WAYS     = 4;

  localparam logic [3:0] OP_READ    = 4'd0;
  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_IFETCH  = 4'd2;
  localparam logic [3:0] OP_SNP_INV = 4'd3;
  localparam logic [3:0] OP_SNP_RD  = 4'd4;
  localparam logic [3:0] OP_SNP_WR  = 4'd5;
  localparam logic [3:0] OP_SNP_RFO = 4'd6;
  localparam logic [3:0] OP_RSVD    = 4'd7;
  localparam logic [3:0] OP_CLEAN   = 4'd8;
  localparam logic [3:0] OP_PRINT   = 4'd9;

  localparam logic [2:0] ST_M = 3'd0;
  localparam logic [2:0] ST_E = 3'd1;
  localparam logic [2:0] ST_S = 3'd2;
  localparam logic [2:0] ST_I = 3'd3;
  localparam logic [2:0] ST_F = 3'd4;

  typedef enum logic [1:0] {
    BUS_READ  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_INVAL = 2'd2,
    BUS_RWIM  = 2'd3
  } bus_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_ISSUE  = 2'd2,
    S_UPDATE = 2'd3
  } fsm_e;

  function automatic logic is_cpu_op(input logic [3:0] op);
    return op <= OP_IFETCH;
  endfunction

endpackage

// File: rtl/plru_tree4.sv
// rtl/plru_tree4.sv - 4-way tree pseudo-LRU victim select and touch update
module plru_tree4 (
  input  logic [2:0] bits_i,
  input  logic [1:0] touch_way_i,
  output logic [1:0] victim_o,
  output logic [2:0] bits_next_o
);

  // b0 picks the older pair, b1/b2 hold the older way inside each pair
  always_comb begin
    victim_o    = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
    bits_next_o = bits_i;
    bits_next_o[0] = ~touch_way_i[1];
    if (touch_way_i[1]) bits_next_o[2] = ~touch_way_i[0];
    else                bits_next_o[1] = ~touch_way_i[0];
  end

endmodule

// File: rtl/cache_lookup.sv
// rtl/cache_lookup.sv - 4-way tag/state lookup feeding the MESIF FSM
module cache_lookup
  import mesif_pkg::*;
#(
  parameter int TAG_BITS    = TAG_W,
  parameter int INDEX_BITS  = INDEX_W,
  parameter int OFFSET_BITS = OFFSET_W,
  parameter int ADDR_BITS   = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [ADDR_BITS-1:0]  cmd_addr,
  output logic                  st_valid,
  output logic [3:0]            st_op,
  output logic [TAG_BITS-1:0]   st_tag,
  output logic [INDEX_BITS-1:0] st_index,
  output logic [1:0]            st_way,
  output logic                  st_hit,
  output logic [2:0]            st_state,
  input  logic                  ns_valid,
  input  logic [2:0]            ns_state,
  output logic                  evict_wb,
  output logic [TAG_BITS-1:0]   evict_tag,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic                  illegal
);

  localparam int SETS = 1 << INDEX_BITS;

  fsm_e fsm_q, fsm_d;

  logic [3:0]            op_q;
  logic [TAG_BITS-1:0]   cmd_tag_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [1:0]            way_q;
  logic                  hit_q;
  logic [2:0]            state_q;
  logic [2:0]            ns_q;
  logic                  illegal_q;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [TAG_BITS-1:0] tags_q   [SETS][WAYS];
  logic [2:0]          states_q [SETS][WAYS];
  logic [2:0]          plru_q   [SETS];

  logic       accept, cpu_op;
  logic [3:0] match, inval;
  logic       any_hit, any_inval;
  logic [1:0] hit_way, inval_way, plru_victim, victim_way, lk_way;
  logic [2:0] lk_state, plru_next;
  logic       unused_offset;

  assign unused_offset = ^cmd_addr[OFFSET_BITS-1:0];
  assign accept        = cmd_valid && cmd_ready;
  assign cpu_op        = is_cpu_op(op_q);

  plru_tree4 u_plru (
    .bits_i      (plru_q[idx_q]),
    .touch_way_i (way_q),
    .victim_o    (plru_victim),
    .bits_next_o (plru_next)
  );

  // Descending scan so the lowest matching / invalid way wins
  always_comb begin
    match     = '0;
    inval     = '0;
    hit_way   = 2'd0;
    inval_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      inval[w] = states_q[idx_q][w] == ST_I;
      match[w] = (tags_q[idx_q][w] == cmd_tag_q) && !inval[w];
      if (match[w]) hit_way = 2'(w);
      if (inval[w]) inval_way = 2'(w);
    end
    any_hit    = |match;
    any_inval  = |inval;
    victim_way = any_inval ? inval_way : plru_victim;
    if (any_hit) begin
      lk_way   = hit_way;
      lk_state = states_q[idx_q][hit_way];
    end else begin
      lk_way   = cpu_op ? victim_way : 2'd0;
      lk_state = ST_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   if (accept && cmd_op <= OP_SNP_RFO) fsm_d = S_LOOKUP;
      S_LOOKUP: fsm_d = S_ISSUE;
      S_ISSUE:  if (ns_valid) fsm_d = S_UPDATE;
      S_UPDATE: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (fsm_q == S_IDLE) && !rst;
    st_valid  = fsm_q == S_ISSUE;
    evict_wb  = (fsm_q == S_LOOKUP) && cpu_op && !any_hit &&
                (states_q[idx_q][victim_way] == ST_M);
    evict_tag = tags_q[idx_q][victim_way];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      cmd_tag_q  <= '0;
      idx_q      <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      state_q    <= '0;
      ns_q       <= '0;
      illegal_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tags_q[s][w]   <= '0;
          states_q[s][w] <= ST_I;
        end
      end
    end else begin
      illegal_q <= accept && (cmd_op == OP_RSVD || cmd_op > OP_PRINT);
      if (accept && cmd_op <= OP_SNP_RFO) begin
        op_q      <= cmd_op;
        idx_q     <= cmd_addr[OFFSET_BITS +: INDEX_BITS];
        cmd_tag_q <= cmd_addr[OFFSET_BITS + INDEX_BITS +: TAG_BITS];
      end
      if (accept && cmd_op == OP_CLEAN) begin
        for (int s = 0; s < SETS; s++) begin
          plru_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            tags_q[s][w]   <= '0;
            states_q[s][w] <= ST_I;
          end
        end
      end
      if (fsm_q == S_LOOKUP) begin
        way_q   <= lk_way;
        hit_q   <= any_hit;
        state_q <= lk_state;
        if (cpu_op && any_hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
        if (cpu_op && !any_hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (fsm_q == S_ISSUE && ns_valid) ns_q <= (ns_state > ST_F) ? ST_I : ns_state;
      if (fsm_q == S_UPDATE) begin
        if (hit_q) begin
          states_q[idx_q][way_q] <= ns_q;
        end else if (cpu_op) begin
          tags_q[idx_q][way_q]   <= cmd_tag_q;
          states_q[idx_q][way_q] <= ns_q;
        end
        if (cpu_op) plru_q[idx_q] <= plru_next;
      end
    end
  end

  assign st_op      = op_q;
  assign st_tag     = cmd_tag_q;
  assign st_index   = idx_q;
  assign st_way     = way_q;
  assign st_hit     = hit_q;
  assign st_state   = state_q;
  assign illegal    = illegal_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_lookup.sv
// tb/tb_cache_lookup.sv - scoreboard bench for cache_lookup
module tb_cache_lookup;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, ns_valid;
  logic        cmd_ready, st_valid, st_hit, evict_wb, illegal;
  logic [3:0]  cmd_op, st_op;
  logic [21:0] cmd_addr;
  logic [11:0] st_tag, evict_tag;
  logic [3:0]  st_index;
  logic [1:0]  st_way;
  logic [2:0]  st_state, ns_state;
  logic [31:0] hit_count, miss_count;

  cache_lookup dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .st_valid(st_valid), .st_op(st_op),
    .st_tag(st_tag), .st_index(st_index), .st_way(st_way), .st_hit(st_hit),
    .st_state(st_state), .ns_valid(ns_valid), .ns_state(ns_state),
    .evict_wb(evict_wb), .evict_tag(evict_tag), .hit_count(hit_count),
    .miss_count(miss_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] tag;
    logic [3:0]  idx;
    logic        hit;
    logic [1:0]  way;
    logic [2:0]  state;
    logic [31:0] hc;
    logic [31:0] mc;
    logic        ev;
    logic [11:0] ev_tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one comparison set per ISSUE entry, evictions latched from LOOKUP
  logic        prev_v = 1'b0;
  logic        ev_seen = 1'b0;
  logic [11:0] ev_tag_seen = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v  = 1'b0;
        ev_seen = 1'b0;
      end else begin
        if (evict_wb) begin
          ev_seen     = 1'b1;
          ev_tag_seen = evict_tag;
        end
        if (st_valid && !prev_v) begin
          if (sb.size() == 0) begin
            chk("unexpected_st_valid", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("st_op", 32'(st_op), 32'(e.op));
            chk("st_tag", 32'(st_tag), 32'(e.tag));
            chk("st_index", 32'(st_index), 32'(e.idx));
            chk("st_hit", 32'(st_hit), 32'(e.hit));
            chk("st_way", 32'(st_way), 32'(e.way));
            chk("st_state", 32'(st_state), 32'(e.state));
            chk("hit_count", hit_count, e.hc);
            chk("miss_count", miss_count, e.mc);
            chk("evict_wb", 32'(ev_seen), 32'(e.ev));
            if (e.ev) chk("evict_tag", 32'(ev_tag_seen), 32'(e.ev_tag));
          end
          ev_seen = 1'b0;
        end
        prev_v = st_valid;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_only(input logic [3:0] op, input logic [21:0] addr);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic xact(input logic [3:0] op, input logic [21:0] addr, input logic [2:0] ns,
                      input bit give_ns, input logic hit, input logic [1:0] way,
                      input logic [2:0] state, input int hc, input int mc,
                      input logic ev, input logic [11:0] ev_tag);
    exp_t e;
    int   n;
    e.op = op; e.tag = addr[21:10]; e.idx = addr[9:6]; e.hit = hit; e.way = way;
    e.state = state; e.hc = 32'(hc); e.mc = 32'(mc); e.ev = ev; e.ev_tag = ev_tag;
    sb.push_back(e);
    send_only(op, addr);
    n = 0;
    @(negedge clk);
    while (!st_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!st_valid) begin
      chk("st_valid_timeout", 32'd0, 32'd1);
    end else if (give_ns) begin
      ns_valid = 1'b1;
      ns_state = ns;
      @(posedge clk);
      #1 ns_valid = 1'b0;
    end
  endtask

  logic [3:0] ill_ops [2];

  initial begin
    ill_ops[0] = 4'd7;
    ill_ops[1] = 4'd10;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    ns_valid = 1'b0; ns_state = '0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("hits_after_reset", hit_count, 32'd0);
    chk("misses_after_reset", miss_count, 32'd0);
    chk("st_valid_after_reset", 32'(st_valid), 32'd0);
    chk("illegal_after_reset", 32'(illegal), 32'd0);

    //    op    addr      ns    give  hit  way  st  hc mc ev evtag
    xact(4'd0, 22'h00040, 3'd1, 1, 0, 2'd0, 3'd3, 0, 1, 0, 12'd0);
    xact(4'd0, 22'h00040, 3'd1, 1, 1, 2'd0, 3'd1, 1, 1, 0, 12'd0);
    send_only(4'd8, 22'h0);
    xact(4'd1, 22'h00440, 3'd0, 1, 0, 2'd0, 3'd3, 1, 2, 0, 12'd0);
    xact(4'd1, 22'h00840, 3'd0, 1, 0, 2'd1, 3'd3, 1, 3, 0, 12'd0);
    xact(4'd1, 22'h00C40, 3'd0, 1, 0, 2'd2, 3'd3, 1, 4, 0, 12'd0);
    xact(4'd1, 22'h01040, 3'd0, 1, 0, 2'd3, 3'd3, 1, 5, 0, 12'd0);
    xact(4'd0, 22'h01440, 3'd1, 1, 0, 2'd0, 3'd3, 1, 6, 1, 12'd1);
    xact(4'd4, 22'h00040, 3'd2, 1, 0, 2'd0, 3'd3, 1, 6, 0, 12'd0);
    xact(4'd4, 22'h00040, 3'd2, 1, 0, 2'd0, 3'd3, 1, 6, 0, 12'd0);
    xact(4'd3, 22'h00840, 3'd0, 1, 1, 2'd1, 3'd0, 1, 6, 0, 12'd0);
    xact(4'd2, 22'h01040, 3'd4, 1, 1, 2'd3, 3'd0, 2, 6, 0, 12'd0);
    send_only(4'd8, 22'h0);
    xact(4'd0, 22'h00840, 3'd1, 1, 0, 2'd0, 3'd3, 2, 7, 0, 12'd0);
    xact(4'd0, 22'h00C40, 3'd7, 1, 0, 2'd1, 3'd3, 2, 8, 0, 12'd0);
    xact(4'd0, 22'h00C40, 3'd1, 1, 0, 2'd1, 3'd3, 2, 9, 0, 12'd0);
    send_only(4'd9, 22'h00840);

    for (int i = 0; i < 2; i++) begin
      send_only(ill_ops[i], 22'h00040);
      @(negedge clk);
      chk("illegal_pulse", 32'(illegal), 32'd1);
      chk("ready_after_illegal", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk("illegal_one_cycle", 32'(illegal), 32'd0);
    end

    xact(4'd0, 22'h01440, 3'd0, 0, 0, 2'd2, 3'd3, 2, 10, 0, 12'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_issue_reset", 32'(cmd_ready), 32'd1);
    chk("st_valid_after_issue_reset", 32'(st_valid), 32'd0);
    chk("hits_after_issue_reset", hit_count, 32'd0);
    chk("misses_after_issue_reset", miss_count, 32'd0);
    chk("st_tag_after_issue_reset", 32'(st_tag), 32'd0);
    xact(4'd0, 22'h00840, 3'd1, 1, 0, 2'd0, 3'd3, 0, 1, 0, 12'd0);
    xact(4'd0, 22'h00840, 3'd1, 1, 1, 2'd0, 3'd1, 1, 1, 0, 12'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_lookup.md
Name: cache_lookup

Overview:
- Upstream stage of the MESIF state machine.
- Accepts trace commands (opcode plus address) and splits the address into tag, index and offset.
- Searches a 4-way set-associative tag/state array and selects a victim on a CPU miss using tree pseudo-LRU.
- Presents the current line state to the MESIF FSM, then writes the returned next state, tag and LRU bits back into the arrays.

Parameters:
- TAG_BITS, 12, address tag width.
- INDEX_BITS, 4, set index width (16 sets).
- OFFSET_BITS, 6, byte offset width (64 B line).
- ADDR_BITS, 22, must equal TAG_BITS+INDEX_BITS+OFFSET_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  trace opcode 0-9.
- cmd_addr  in  ADDR_BITS  byte address.
- st_valid  out  1  lookup result presented to the MESIF FSM.
- st_op  out  4  registered opcode.
- st_tag  out  TAG_BITS  registered tag.
- st_index  out  INDEX_BITS  registered index.
- st_way  out  2  hit way, or victim way on a miss.
- st_hit  out  1  tag match with state != I.
- st_state  out  3  current state of st_way: M=0 E=1 S=2 I=3 F=4. Reads I on a miss.
- ns_valid  in  1  MESIF next state is valid.
- ns_state  in  3  next state from the MESIF FSM.
- evict_wb  out  1  one-cycle pulse: the victim was M and needs a writeback.
- evict_tag  out  TAG_BITS  tag of the evicted line.
- hit_count  out  32  CPU hits (ops 0,1,2).
- miss_count  out  32  CPU misses (ops 0,1,2).
- illegal  out  1  one-cycle pulse on opcode 7 or >9.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. Takes priority over everything, including mid-transaction.
  - FSM goes to IDLE and any in-flight command is dropped without array update.
  - All 64 line states become I; tags become 0; PLRU bits become 0.
  - Outputs: cmd_ready=0 during reset and 1 the cycle after; st_valid=0; evict_wb=0; illegal=0; counters=0; st_* data=0.
- States: IDLE, LOOKUP, ISSUE, UPDATE.
- IDLE:
  - cmd_ready=1. A command is accepted when cmd_valid and cmd_ready are both 1.
  - The accepted command is registered; the FSM goes to LOOKUP.
  - cmd_ready=0 in every other state.
- Accepted op 8 (clean): in the same edge, all states become I, tags 0, PLRU 0. Counters are not cleared. FSM stays in IDLE.
- Accepted op 9 (print): no array effect. FSM stays in IDLE.
- Accepted op 7 or >9: illegal pulses for 1 cycle. No array effect. FSM stays in IDLE.
- LOOKUP (1 cycle): compare the tag against all 4 ways of the set.
  - Hit means the tag matches and the state is not I. At most one way can hit; if more than one matches, the lowest way wins.
  - CPU miss (op 0/1/2): victim is the lowest-numbered way in state I. If there is none, the victim is the PLRU way.
  - If the victim state is M, evict_wb pulses in this cycle with evict_tag set to the victim tag.
  - CPU op: hit_count or miss_count increments in this cycle. The counters saturate at 0xFFFF_FFFF.
  - Snoop miss (op 3-6): st_way=0 and st_state=I.
  - FSM goes to ISSUE.
- ISSUE:
  - st_valid=1 and all st_* outputs stay stable.
  - The block waits indefinitely for ns_valid; ns_valid in any other state is ignored.
  - When ns_valid=1, ns_state is captured and the FSM goes to UPDATE.
- UPDATE (1 cycle):
  - Hit: the state of st_way is written with ns_state.
  - CPU miss: the tag of st_way is written with st_tag and its state with ns_state.
  - Snoop miss: nothing is written.
  - PLRU is updated on CPU hits and fills only, so that st_way is marked most recently used. Tree encoding:
    - b0 chooses the pair (0: ways 0-1 older, 1: ways 2-3 older).
    - b1 chooses within ways 0/1; b2 chooses within ways 2/3.
    - The victim is found by following the older branch at each level.
    - On touch, the bits along the path are set to point away from the touched way.
  - ns_state values above 4 are written as I.
  - FSM goes to IDLE.
- Throughput: one non-trivial command takes 4 cycles if ns_valid is returned in the first ISSUE cycle. Back-to-back acceptance is possible on the cycle after UPDATE.

Decomposition:
- Package mesif_pkg holds:
  - opcode constants 0-9;
  - state encodings M/E/S/I/F;
  - bus operation codes;
  - the address field widths.
- One sub-module, plru_tree4: combinational victim select plus next-PLRU computation from the 3 bits and the touched way. It is shared with any future L2 model.

Test Plan:
- rst high for 2 cycles -> cmd_ready=0 while rst is high and 1 the cycle after; counters 0; a read of 0x00040 gives st_hit=0, st_state=3, st_way=0, miss_count=1.
- Op 0 at 0x00040, FSM returns E(1); then op 0 at 0x00040 again -> st_hit=1, st_way=0, st_state=1, hit_count=1.
- Fill ways 0-3 of set 1 with tags 1-4 (op 1, ns=M), touching them in order 0,1,2,3; then op 0 with tag 5 -> victim way 0, evict_wb pulses with evict_tag=1.
- Op 4 (snoop read) to an absent tag -> st_hit=0, st_state=3; the arrays are unchanged even when ns_state=2 is returned.
- Op 8 after the fills -> the next access to any prior address misses; counters are retained.
- Op 7 -> illegal pulses for 1 cycle, cmd_ready stays 1, and there is no st_valid. Separately, assert rst while in ISSUE -> IDLE on the next cycle and all lines read I.
